// File: rtl/fib_demo_seq.sv
// fib_demo_seq: writes SEED0, SEED1, then a Fibonacci series into r0..r(NUM_REGS-1), one write per STEP_DIV cycles.
// Latency: first write pulses the cycle after the edge following start; every output is registered.
// Backpressure: pause freezes the divider and writes; define FIB_DEMO_LOOP_EN to repeat automatically after done.
module fib_demo_seq #(
   parameter int WIDTH    = 16,
   parameter int NUM_REGS = 16,
   parameter int STEP_DIV = 1,
   parameter logic [WIDTH-1:0] SEED0 = '0,
   parameter logic [WIDTH-1:0] SEED1 = WIDTH'(1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        pause,
   output logic [NUM_REGS-1:0]         reg_wr_en,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic [WIDTH-1:0]            wr_data,
   output logic [4:0]                  flags,
   output logic [WIDTH-1:0]            disp_value,
   output logic                        busy,
   output logic                        done
);

   localparam int AW = $clog2(NUM_REGS);
   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DW-1:0] DIV_RELOAD = DW'(STEP_DIV - 1);
   localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_REGS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT0 = 3'd1;
   localparam logic [2:0] S_INIT1 = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state;
   logic [DW-1:0]    div_cnt;
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] prev2;

   logic             active;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] wdata_nxt;
   logic [4:0]       add_flags;

   assign active  = (state == S_INIT0) || (state == S_INIT1) || (state == S_RUN);
   assign sum_ext = {1'b0, prev} + {1'b0, prev2};

   // prev is r[k-1] (operand a), prev2 is r[k-2] (operand b)
   always_comb begin
      add_flags    = '0;
      add_flags[4] = sum_ext[WIDTH];
      add_flags[3] = prev < prev2;
      add_flags[2] = (prev[WIDTH-1] == prev2[WIDTH-1]) && (sum_ext[WIDTH-1] != prev[WIDTH-1]);
      add_flags[1] = (sum_ext[WIDTH-1:0] == '0);
      add_flags[0] = sum_ext[WIDTH-1];
   end

   always_comb begin
      wdata_nxt = sum_ext[WIDTH-1:0];
      if (state == S_INIT0)
         wdata_nxt = SEED0;
      else if (state == S_INIT1)
         wdata_nxt = SEED1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         idx        <= '0;
         prev       <= '0;
         prev2      <= '0;
         reg_wr_en  <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
         flags      <= '0;
         disp_value <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         reg_wr_en <= '0;
         busy      <= active;
         done      <= (state == S_DONE);
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_INIT0;
                  div_cnt <= '0;
                  idx     <= '0;
               end
            end
            S_INIT0, S_INIT1, S_RUN: begin
               if (!pause) begin
                  if (div_cnt != '0) begin
                     div_cnt <= div_cnt - DW'(1);
                  end else begin
                     div_cnt    <= DIV_RELOAD;
                     reg_wr_en  <= NUM_REGS'(1) << idx;
                     wr_addr    <= idx;
                     wr_data    <= wdata_nxt;
                     disp_value <= wdata_nxt;
                     flags      <= (state == S_RUN) ? add_flags : 5'd0;
                     prev2      <= prev;
                     prev       <= wdata_nxt;
                     idx        <= idx + AW'(1);
                     if (state == S_INIT0)
                        state <= S_INIT1;
                     else if (state == S_INIT1)
                        state <= S_RUN;
                     else if (idx == LAST_IDX)
                        state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
`ifdef FIB_DEMO_LOOP_EN
               // div_cnt was reloaded by the last write, so done is held STEP_DIV cycles
               if (div_cnt == '0) begin
                  state <= S_INIT0;
                  idx   <= '0;
               end else begin
                  div_cnt <= div_cnt - DW'(1);
               end
`else
               if (start) begin
                  state   <= S_INIT0;
                  div_cnt <= '0;
                  idx     <= '0;
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_demo_seq.sv
// Bench for fib_demo_seq: instance a is 16-bit/STEP_DIV=1, instance b is 8-bit/STEP_DIV=4.
// An abstract Fibonacci model checks every cycle; directed steps cover pause, reset, restart and ignored start.
module tb_fib_demo_seq;

   localparam int S0 = 0;
   localparam int S1 = 1;

   logic clk = 1'b0;
   logic rst_a, start_a, pause_a;
   logic rst_b, start_b, pause_b;

   logic [15:0] a_we;
   logic [3:0]  a_ad;
   logic [15:0] a_wd;
   logic [4:0]  a_fl;
   logic [15:0] a_dv;
   logic        a_bz, a_dn;

   logic [15:0] b_we;
   logic [3:0]  b_ad;
   logic [7:0]  b_wd;
   logic [4:0]  b_fl;
   logic [7:0]  b_dv;
   logic        b_bz, b_dn;

   fib_demo_seq #(.WIDTH(16), .NUM_REGS(16), .STEP_DIV(1), .SEED0(16'(S0)), .SEED1(16'(S1))) u_a (
      .clk(clk), .rst(rst_a), .start(start_a), .pause(pause_a),
      .reg_wr_en(a_we), .wr_addr(a_ad), .wr_data(a_wd), .flags(a_fl),
      .disp_value(a_dv), .busy(a_bz), .done(a_dn)
   );

   fib_demo_seq #(.WIDTH(8), .NUM_REGS(16), .STEP_DIV(4), .SEED0(8'(S0)), .SEED1(8'(S1))) u_b (
      .clk(clk), .rst(rst_b), .start(start_b), .pause(pause_b),
      .reg_wr_en(b_we), .wr_addr(b_ad), .wr_data(b_wd), .flags(b_fl),
      .disp_value(b_dv), .busy(b_bz), .done(b_dn)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   // per-instance model state
   int          k_[2], last_[2], gap_[2], pc_[2], np_[2];
   int          pt_[2][16];
   bit          act_[2], fin_[2];
   logic [15:0] lv_[2];
   logic [4:0]  lf_[2];

   task automatic check(input string nm, input bit ok, input longint got, input longint exp);
      nchk++;
      if (!ok) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // r[k] modulo 2^w
   function automatic longint fibv(input int k, input int w);
      longint m = 1;
      longint x = S0;
      longint y = S1;
      longint t;
      m = m << w;
      if (k == 0) return x;
      for (int i = 2; i <= k; i++) begin
         t = (x + y) % m;
         x = y;
         y = t;
      end
      return y;
   endfunction

   // {C,L,F,Z,N} of r[k-1]+r[k-2], from integer arithmetic
   function automatic logic [4:0] fibf(input int k, input int w);
      longint m = 1;
      longint h, a, b, s, sa, sb;
      m = m << w;
      h = m / 2;
      if (k < 2) return 5'd0;
      a  = fibv(k - 1, w);
      b  = fibv(k - 2, w);
      s  = a + b;
      sa = (a >= h) ? a - m : a;
      sb = (b >= h) ? b - m : b;
      return {s >= m, a < b, (sa + sb < -h) || (sa + sb >= h), (s % m) == 0, (s % m) >= h};
   endfunction

   task automatic model(input int id, input int w, input int d, input logic rv, input logic st,
                        input logic ps, input logic [15:0] we, input logic [3:0] ad,
                        input logic [15:0] wd, input logic [4:0] fl, input logic [15:0] dv,
                        input logic bz, input logic dn);
      int ek;
      if (!rv) begin
         check("rst_outs", {we, ad, wd, fl, dv, bz, dn} == '0, we, 0);
         act_[id] = 0; fin_[id] = 0; k_[id] = 0; lv_[id] = '0; lf_[id] = '0;
         return;
      end
      if (we != '0) begin
         np_[id]++;
         if (!act_[id]) begin
            check("spurious_pulse", 0, we, 0);
         end else begin
            ek = k_[id];
            check("pulse_gap", cyc - last_[id] == gap_[id] + pc_[id], cyc - last_[id], gap_[id] + pc_[id]);
            check("onehot", we == (16'd1 << ek), we, 1 << ek);
            check("wr_addr", ad == 4'(ek), ad, ek);
            check("wr_data", wd == 16'(fibv(ek, w)), wd, fibv(ek, w));
            check("flags", fl == fibf(ek, w), fl, fibf(ek, w));
            check("busy_in_run", bz && !dn, {bz, dn}, 2);
            pt_[id][ek] = cyc;
            lv_[id] = 16'(fibv(ek, w));
            lf_[id] = fibf(ek, w);
            last_[id] = cyc; pc_[id] = 0; gap_[id] = d; k_[id] = ek + 1;
            if (k_[id] == 16) begin
               k_[id] = 0; fin_[id] = 1;
`ifdef FIB_DEMO_LOOP_EN
               gap_[id] = d + 1;
`else
               act_[id] = 0;
`endif
            end
         end
      end else begin
         if (fin_[id]) begin
            check("done_after_last", !bz && dn, {bz, dn}, 1);
            fin_[id] = 0;
         end
         if (act_[id] && cyc - last_[id] > gap_[id] + pc_[id]) begin
            check("missing_pulse", 0, cyc - last_[id], gap_[id] + pc_[id]);
            act_[id] = 0;
         end
      end
      check("disp_hold", dv == lv_[id], dv, lv_[id]);
      check("flags_hold", fl == lf_[id], fl, lf_[id]);
      if (act_[id] && ps) pc_[id]++;
      if (st && !act_[id]) begin
         act_[id] = 1; k_[id] = 0; last_[id] = cyc + 1; gap_[id] = 1; pc_[id] = 0;
      end
   endtask

   // one cycle: model compare on the falling edge, then stimulus point just after the rising edge
   task automatic tick();
      @(negedge clk);
      model(0, 16, 1, rst_a, start_a, pause_a, a_we, a_ad, a_wd, a_fl, a_dv, a_bz, a_dn);
      model(1, 8, 4, rst_b, start_b, pause_b, b_we, b_ad, {8'd0, b_wd}, b_fl, {8'd0, b_dv}, b_bz, b_dn);
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic wait_done(input int id, input int budget);
      int n = 0;
      while (!(id == 0 ? a_dn : b_dn) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check("done_timeout", 0, n, budget);
   endtask

   task automatic wait_np(input int id, input int target, input int budget);
      int n = 0;
      while (np_[id] < target && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check("pulse_timeout", 0, np_[id], target);
   endtask

   initial begin
      int base;
      for (int i = 0; i < 2; i++) begin
         k_[i] = 0; last_[i] = 0; gap_[i] = 1; pc_[i] = 0; np_[i] = 0;
         act_[i] = 0; fin_[i] = 0; lv_[i] = '0; lf_[i] = '0;
      end
      rst_a = 1'b1; rst_b = 1'b1;
      start_a = 1'b0; pause_a = 1'b0; start_b = 1'b0; pause_b = 1'b0;
      #2;
      rst_a = 1'b0; rst_b = 1'b0;
      #1;
      check("reset_a", {a_we, a_ad, a_wd, a_fl, a_dv, a_bz, a_dn} == '0, a_dv, 0);
      check("reset_b", {b_we, b_ad, b_wd, b_fl, b_dv, b_bz, b_dn} == '0, b_dv, 0);

      check("pin_r15_w16", fibv(15, 16) == 610, fibv(15, 16), 610);
      check("pin_f15_w16", fibf(15, 16) == 5'b00000, fibf(15, 16), 0);
      check("pin_r12_w8", fibv(12, 8) == 144, fibv(12, 8), 144);
      check("pin_f12_w8", fibf(12, 8) == 5'b00101, fibf(12, 8), 5);
      check("pin_f13_w8", fibf(13, 8) == 5'b00001, fibf(13, 8), 1);
      check("pin_r14_w8", fibv(14, 8) == 121, fibv(14, 8), 121);
      check("pin_f14_w8", fibf(14, 8) == 5'b10100, fibf(14, 8), 20);
      check("pin_r15_w8", fibv(15, 8) == 98, fibv(15, 8), 98);
      check("pin_f15_w8", fibf(15, 8) == 5'b11000, fibf(15, 8), 24);

      repeat (3) tick();
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (2) tick();

      // a: back-to-back writes; a start during the run must be ignored
      start_a = 1'b1; tick(); start_a = 1'b0; tick();
      check("busy_rise_a", a_bz && !a_dn, {a_bz, a_dn}, 2);
      repeat (4) tick();
      start_a = 1'b1; tick(); start_a = 1'b0;
      wait_done(0, 60);
      check("a_last_disp", a_dv == 16'd610, a_dv, 610);
      check("a_last_flags", a_fl == 5'd0, a_fl, 0);
      check("a_busy_low", !a_bz, a_bz, 0);
`ifndef FIB_DEMO_LOOP_EN
      check("a_pulse_count", np_[0] == 16, np_[0], 16);
      repeat (10) tick();
      check("a_done_holds", a_dn && np_[0] == 16, np_[0], 16);
      start_a = 1'b1; tick(); start_a = 1'b0; tick();
      wait_done(0, 60);
      check("a_restart_disp", a_dv == 16'd610, a_dv, 610);
      check("a_restart_count", np_[0] == 32, np_[0], 32);
`else
      wait_np(0, 32, 80);
      check("a_loop_rerun", np_[0] >= 32, np_[0], 32);
`endif

      // b: start with pause held, then a 10-cycle pause after write 3
      start_b = 1'b1; pause_b = 1'b1; tick(); start_b = 1'b0;
      repeat (3) tick();
      pause_b = 1'b0;
      wait_np(1, 4, 200);
      pause_b = 1'b1; repeat (10) tick(); pause_b = 1'b0;
      wait_done(1, 200);
      check("b_gap_1_0", pt_[1][1] - pt_[1][0] == 4, pt_[1][1] - pt_[1][0], 4);
      check("b_gap_4_3", pt_[1][4] - pt_[1][3] == 14, pt_[1][4] - pt_[1][3], 14);
      check("b_gap_5_4", pt_[1][5] - pt_[1][4] == 4, pt_[1][5] - pt_[1][4], 4);
      check("b_last_disp", b_dv == 8'd98, b_dv, 98);
      check("b_last_flags", b_fl == 5'b11000, b_fl, 24);

      // b: restart from done, reset between writes 5 and 6
      base = np_[1];
      start_b = 1'b1; tick(); start_b = 1'b0; tick();
      wait_np(1, base + 6, 100);
      tick();
      #1 rst_b = 1'b0;
      #1 check("b_midrun_reset", {b_we, b_ad, b_wd, b_fl, b_dv, b_bz, b_dn} == '0, b_dv, 0);
      repeat (3) tick();
      rst_b = 1'b1;
      repeat (20) tick();
      check("b_no_pulse_after_reset", np_[1] == base + 6, np_[1], base + 6);
      check("b_idle_after_reset", !b_bz && !b_dn, {b_bz, b_dn}, 0);
      start_b = 1'b1; tick(); start_b = 1'b0; tick();
      wait_done(1, 200);
      check("b_rerun_disp", b_dv == 8'd98, b_dv, 98);
      check("b_rerun_count", np_[1] == base + 22, np_[1], base + 22);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
